// File: rtl/bmb_mem_pkg.sv
// Shared types, default widths and FSM encodings for the BMB-to-memory arbiter.
package bmb_mem_pkg;

    localparam int DefNumReq      = 2;
    localparam int DefAddrSize    = 32;
    localparam int DefDataSize    = 64;
    localparam int DefPayloadBits = 2;

    typedef logic [DefAddrSize-1:0]   addr_t;
    typedef logic [DefDataSize-1:0]   data_t;
    typedef logic [DefDataSize/8-1:0] strb_t;

    typedef struct packed {
        addr_t                     address;
        logic [DefPayloadBits-1:0] size;
        logic                      wr;
        data_t                     data;
        strb_t                     mask;
        logic                      last;
    } bmb_cmd_t;

    typedef logic [$clog2(DefNumReq)-1:0] req_idx_t;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Round-robin successor of idx among n requesters.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bmb_mem_arbiter_rr_arbiter.sv
// Combinational round-robin selector with lock override.
module rr_arbiter #(
    parameter int NumReq = 2,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   rr_ptr,
    input  logic              lock,
    input  logic [IdxW-1:0]   owner,
    output logic [NumReq-1:0] sel_oh,
    output logic [IdxW-1:0]   sel_idx
);

    always_comb begin
        logic found;
        int   idx;
        found   = 1'b0;
        idx     = 0;
        sel_idx = rr_ptr;
        if (lock) begin
            sel_idx = owner;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                idx = (int'(rr_ptr) + k) % NumReq;
                if (!found && req[idx]) begin
                    found   = 1'b1;
                    sel_idx = IdxW'(idx);
                end
            end
        end
        sel_oh          = '0;
        sel_oh[sel_idx] = 1'b1;
    end

endmodule

// File: rtl/bmb_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NumReq BMB requesters.
//   state  | meaning
//   IDLE   | free; next grant chosen round-robin from rr_ptr
//   LOCKED | owner is mid multi-beat command; everyone else stalls
module bmb_mem_arbiter
    import bmb_mem_pkg::*;
#(
    parameter int NumReq      = DefNumReq,
    parameter int AddrSize    = DefAddrSize,
    parameter int DataSize    = DefDataSize,
    parameter int PayloadBits = DefPayloadBits
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   bmb_cmd_valid,
    output logic [NumReq-1:0]                   bmb_cmd_ready,
    input  logic [NumReq-1:0][AddrSize-1:0]     bmb_cmd_payload_address,
    input  logic [NumReq-1:0][PayloadBits-1:0]  bmb_cmd_payload_size,
    input  logic [NumReq-1:0]                   bmb_cmd_payload_wr,
    input  logic [NumReq-1:0][DataSize-1:0]     bmb_cmd_payload_data,
    input  logic [NumReq-1:0][DataSize/8-1:0]   bmb_cmd_payload_mask,
    input  logic [NumReq-1:0]                   bmb_cmd_payload_last,
    output logic [NumReq-1:0]                   bmb_rsp_valid,
    output logic [DataSize-1:0]                 bmb_rsp_payload_data,
    output logic [NumReq-1:0]                   bmb_rsp_payload_last,
    output logic [NumReq-1:0]                   bmb_rsp_payload_error,
    output logic                                mem_req,
    input  logic                                mem_gnt,
    output logic [AddrSize-1:0]                 mem_addr,
    output logic [DataSize-1:0]                 mem_wdata,
    output logic [DataSize/8-1:0]               mem_strb,
    output logic                                mem_we,
    input  logic [DataSize-1:0]                 mem_rdata
);

    localparam int IdxW = $clog2(NumReq);

    logic [0:0]        state_q;
    logic [IdxW-1:0]   owner_q;
    logic [IdxW-1:0]   rr_ptr_q;
    logic              rsp_pend_q;
    logic [IdxW-1:0]   rsp_owner_q;

    logic [NumReq-1:0] sel_oh;
    logic [IdxW-1:0]   sel_idx;
    logic              accept;
    logic              sel_last;
    logic              unused_size;

    // The memory has no size field; transfers are always full-width beats.
    assign unused_size = ^bmb_cmd_payload_size;

    rr_arbiter #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_arbiter (
        .req     (bmb_cmd_valid),
        .rr_ptr  (rr_ptr_q),
        .lock    (state_q == ST_LOCKED),
        .owner   (owner_q),
        .sel_oh  (sel_oh),
        .sel_idx (sel_idx)
    );

    assign mem_req       = |(bmb_cmd_valid & sel_oh);
    assign accept        = mem_req & mem_gnt;
    assign bmb_cmd_ready = accept ? sel_oh : '0;

    assign mem_addr  = bmb_cmd_payload_address[sel_idx];
    assign mem_wdata = bmb_cmd_payload_data[sel_idx];
    assign mem_strb  = bmb_cmd_payload_mask[sel_idx];
    assign mem_we    = bmb_cmd_payload_wr[sel_idx];
    assign sel_last  = bmb_cmd_payload_last[sel_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            rsp_pend_q  <= 1'b0;
            rsp_owner_q <= '0;
        end else begin
            rsp_pend_q <= accept & ~mem_we;
            if (accept && !mem_we) begin
                rsp_owner_q <= sel_idx;
            end
            if (accept) begin
                if (sel_last) begin
                    state_q  <= ST_IDLE;
                    rr_ptr_q <= IdxW'(wrap_inc(int'(sel_idx), NumReq));
                end else begin
                    state_q <= ST_LOCKED;
                    owner_q <= sel_idx;
                end
            end
        end
    end

    always_comb begin
        bmb_rsp_valid = '0;
        for (int i = 0; i < NumReq; i++) begin
            bmb_rsp_valid[i] = rsp_pend_q && (rsp_owner_q == IdxW'(i));
        end
    end

    assign bmb_rsp_payload_data  = mem_rdata;
    assign bmb_rsp_payload_last  = '1;
    assign bmb_rsp_payload_error = '0;

endmodule

// File: tb/tb_bmb_mem_arbiter.sv
// Directed and randomized bench for bmb_mem_arbiter against a cycle-level reference model.
module tb_bmb_mem_arbiter;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [1:0]       valid;
    logic [1:0]       ready;
    logic [1:0][31:0] addr;
    logic [1:0][1:0]  size;
    logic [1:0]       wr;
    logic [1:0][63:0] wdata;
    logic [1:0][7:0]  mask;
    logic [1:0]       last;
    logic [1:0]       rsp_valid;
    logic [63:0]      rsp_data;
    logic [1:0]       rsp_last;
    logic [1:0]       rsp_error;
    logic             mem_req;
    logic             gnt;
    logic [31:0]      mem_addr;
    logic [63:0]      mem_wdata;
    logic [7:0]       mem_strb;
    logic             mem_we;
    logic [63:0]      rdata;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // reference model: -1 means "none"
    int m_owner;
    int m_rr;
    int m_rsp;
    int g_hist[$];

    always #5 clk_i = ~clk_i;

    bmb_mem_arbiter dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .bmb_cmd_valid           (valid),
        .bmb_cmd_ready           (ready),
        .bmb_cmd_payload_address (addr),
        .bmb_cmd_payload_size    (size),
        .bmb_cmd_payload_wr      (wr),
        .bmb_cmd_payload_data    (wdata),
        .bmb_cmd_payload_mask    (mask),
        .bmb_cmd_payload_last    (last),
        .bmb_rsp_valid           (rsp_valid),
        .bmb_rsp_payload_data    (rsp_data),
        .bmb_rsp_payload_last    (rsp_last),
        .bmb_rsp_payload_error   (rsp_error),
        .mem_req                 (mem_req),
        .mem_gnt                 (gnt),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_strb                (mem_strb),
        .mem_we                  (mem_we),
        .mem_rdata               (rdata)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_rsp   = -1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a,
                           input logic w, input logic [7:0] m, input logic l);
        valid[i] = v;
        addr[i]  = a;
        wr[i]    = w;
        mask[i]  = m;
        last[i]  = l;
        wdata[i] = {$urandom, $urandom};
    endtask

    // Called at a falling edge with inputs applied; checks, advances model, returns at next falling edge.
    task automatic step();
        int         sel;
        logic       e_req;
        logic       acc;
        logic [1:0] e_ready;
        rdata = {$urandom, $urandom};
        #1;
        sel = -1;
        if (m_owner >= 0) sel = m_owner;
        else begin
            for (int k = 0; k < 2; k++) begin
                if (sel < 0 && valid[(m_rr + k) % 2]) sel = (m_rr + k) % 2;
            end
        end
        e_req = 1'b0;
        if (sel >= 0) e_req = valid[sel];
        acc     = e_req && gnt;
        e_ready = acc ? 2'(1 << sel) : 2'b00;
        chk("cmd_ready", 128'(ready), 128'(e_ready));
        chk("mem_req", 128'(mem_req), 128'(e_req));
        if (e_req) begin
            chk("mem_cmd", 128'({mem_addr, mem_we, mem_strb, mem_wdata}),
                128'({addr[sel], wr[sel], mask[sel], wdata[sel]}));
        end
        chk("rsp_valid", 128'(rsp_valid), 128'((m_rsp >= 0) ? 2'(1 << m_rsp) : 2'b00));
        if (m_rsp >= 0) chk("rsp_data", 128'(rsp_data), 128'(rdata));
        chk("rsp_last_err", 128'({rsp_last, rsp_error}), 128'(4'b1100));
        if (acc) begin
            g_hist.push_back(sel);
            m_rsp = wr[sel] ? -1 : sel;
            if (last[sel]) begin
                m_owner = -1;
                m_rr    = (sel + 1) % 2;
            end else begin
                m_owner = sel;
            end
        end else begin
            m_rsp = -1;
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        valid  = 2'b00;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        int n0;
        rst_ni = 1'b0;
        valid  = '0;
        addr   = '0;
        size   = '0;
        wr     = '0;
        wdata  = '0;
        mask   = '0;
        last   = '0;
        gnt    = 1'b1;
        rdata  = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        chk("reset_rsp_valid", 128'(rsp_valid), 128'(2'b00));
        chk("reset_ready", 128'(ready), 128'(2'b00));
        chk("reset_mem_req", 128'(mem_req), 128'(1'b0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // single read on requester 0
        set_req(0, 1'b1, 32'h8000_0000, 1'b0, 8'hFF, 1'b1);
        #1 chk("single_addr", 128'(mem_addr), 128'(32'h8000_0000));
        step();
        valid = 2'b00;
        step();

        // both requesters reading every cycle
        do_reset();
        n0 = g_hist.size();
        for (int c = 0; c < 6; c++) begin
            set_req(0, 1'b1, $urandom, 1'b0, 8'hFF, 1'b1);
            set_req(1, 1'b1, $urandom, 1'b0, 8'hFF, 1'b1);
            step();
        end
        valid = 2'b00;
        step();
        for (int c = 0; c < 6; c++) chk("alternate", 128'(g_hist[n0 + c]), 128'(c % 2));

        // requester 1 four-beat burst while requester 0 stays valid
        do_reset();
        set_req(0, 1'b1, 32'h100, 1'b0, 8'hFF, 1'b1);
        step();
        n0 = g_hist.size();
        for (int b = 0; b < 4; b++) begin
            set_req(0, 1'b1, 32'h200, 1'b0, 8'hFF, 1'b1);
            set_req(1, 1'b1, 32'h300 + 32'(b * 8), 1'b0, 8'hFF, b == 3);
            step();
        end
        valid[1] = 1'b0;
        step();
        valid = 2'b00;
        step();
        for (int b = 0; b < 5; b++) chk("burst_order", 128'(g_hist[n0 + b]), 128'((b < 4) ? 1 : 0));

        // backpressure
        do_reset();
        n0 = g_hist.size();
        set_req(0, 1'b1, 32'h400, 1'b0, 8'hFF, 1'b1);
        gnt = 1'b0;
        repeat (3) step();
        gnt = 1'b1;
        step();
        valid = 2'b00;
        step();
        chk("gnt_one_beat", 128'(g_hist.size() - n0), 128'(1));

        // write from requester 1
        set_req(1, 1'b1, 32'h500, 1'b1, 8'hF0, 1'b1);
        #1;
        chk("write_we", 128'(mem_we), 128'(1'b1));
        chk("write_strb", 128'(mem_strb), 128'(8'hF0));
        step();
        valid = 2'b00;
        step();

        // reset in the middle of a locked read burst
        do_reset();
        set_req(1, 1'b1, 32'h600, 1'b0, 8'hFF, 1'b1);
        step();
        set_req(1, 1'b1, 32'h700, 1'b0, 8'hFF, 1'b0);
        step();
        step();
        #2 rst_ni = 1'b0;
        #1 chk("midreset_rsp", 128'(rsp_valid), 128'(2'b00));
        valid = 2'b00;
        #1;
        chk("midreset_req", 128'(mem_req), 128'(1'b0));
        chk("midreset_ready", 128'(ready), 128'(2'b00));
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        n0 = g_hist.size();
        set_req(0, 1'b1, 32'h800, 1'b0, 8'hFF, 1'b1);
        set_req(1, 1'b1, 32'h900, 1'b0, 8'hFF, 1'b1);
        step();
        valid = 2'b00;
        step();
        chk("post_reset_winner", 128'(g_hist[n0]), 128'(0));

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                set_req(i, ($urandom % 4) != 0, $urandom, $urandom % 2, 8'($urandom),
                        ($urandom % 3) != 0);
            end
            gnt = ($urandom % 4) != 0;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bmb_mem_arbiter.md
# bmb_mem_arbiter

Shares one single-port memory request/grant interface between `NumReq` BMB requesters, e.g. the VexRiscv instruction and data buses, in front of the testbench memory model. Selection is round-robin. Arbitration locks onto the current owner for the full duration of a multi-beat command. The block honours `mem_gnt` backpressure and routes each read response back to the requester that issued it. Placement: between the CPU BMB ports and the memory model, taking the place of a direct one-to-one BMB-to-memory converter.

## Interface
Parameters:
- `NumReq`, 2: number of BMB requesters. Must be ≥ 2.
- `AddrSize`, 32: address width.
- `DataSize`, 64: data width. Strobe width is `DataSize/8`.
- `PayloadBits`, 2: width of the BMB size field.

Ports (per-requester signals are packed arrays, index `i` ∈ [0, `NumReq`)):
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `bmb_cmd_valid`  in  NumReq  command valid, per requester.
- `bmb_cmd_ready`  out  NumReq  command accepted, per requester.
- `bmb_cmd_payload_address`  in  NumReq×AddrSize  address.
- `bmb_cmd_payload_size`  in  NumReq×PayloadBits  size. Not forwarded.
- `bmb_cmd_payload_wr`  in  NumReq  1 = write.
- `bmb_cmd_payload_data`  in  NumReq×DataSize  write data.
- `bmb_cmd_payload_mask`  in  NumReq×DataSize/8  byte strobe.
- `bmb_cmd_payload_last`  in  NumReq  last beat of a command.
- `bmb_rsp_valid`  out  NumReq  read response valid, per requester.
- `bmb_rsp_payload_data`  out  DataSize  read data, shared by all requesters.
- `bmb_rsp_payload_last`  out  NumReq  always 1.
- `bmb_rsp_payload_error`  out  NumReq  always 0.
- `mem_req`  out  1  memory request.
- `mem_gnt`  in  1  memory accepted the request this cycle.
- `mem_addr`, `mem_wdata`, `mem_strb`, `mem_we`  out  per memory port  muxed from the selected requester.
- `mem_rdata`  in  DataSize  read data, valid one cycle after an accepted read.

## Operation
Beat acceptance:
- A beat is accepted when `mem_req & mem_gnt` holds.
- On acceptance, `bmb_cmd_ready[sel]` = 1. All other `bmb_cmd_ready` bits are 0 in every cycle.

State machine, states `IDLE` and `LOCKED(owner)`:
- In `IDLE`: `sel` = the first `i` with `bmb_cmd_valid[i]`=1, searching from `rr_ptr` upward modulo `NumReq`.
- In `LOCKED`: `sel` = `owner`, whatever the other valids are.

Memory outputs:
- `mem_req` = `bmb_cmd_valid[sel]`.
- In `IDLE`, `mem_req` is 0 if no valid is set.
- In `LOCKED`, `mem_req` is 0 while the owner deasserts valid. The lock is held regardless and other requesters stay stalled.
- `mem_addr`/`mem_wdata`/`mem_strb`/`mem_we` are combinationally muxed from `sel`. Their value is don't-care when `mem_req`=0.

Transitions, on an accepted beat:
- `last`=0: go to or stay in `LOCKED(sel)`.
- `last`=1: go to `IDLE` and set `rr_ptr` ← (`sel`+1) mod `NumReq`.
- A single-beat command never enters `LOCKED`.

Read responses:
- An accepted beat with `mem_we`=0 sets `rsp_pend_q` ← 1 and `rsp_owner_q` ← `sel` for the next cycle. Otherwise `rsp_pend_q` ← 0.
- `bmb_rsp_valid[i]` = `rsp_pend_q & (rsp_owner_q == i)`.
- `bmb_rsp_payload_data` = `mem_rdata`.
- Responses have no backpressure. Requesters must sink them.

Writes:
- Writes produce no response.

## Timing
- Command path (`bmb_cmd_valid`/`payload` → `mem_*`, and `mem_gnt` → `bmb_cmd_ready`) is combinational, with zero added latency.
- Read latency: `bmb_rsp_valid` asserts exactly 1 cycle after the accepted read.
- Back-to-back accepted reads produce responses on consecutive cycles, including when they come from different requesters.
- A new grant never waits for a pending response.
- Simultaneous valids: exactly one requester is selected, per `rr_ptr`.
- `mem_gnt`=0: nothing is accepted and no state changes. `sel` may change in the next cycle only while in `IDLE`.
- Reset values: `rr_ptr`=0, state `IDLE`, `rsp_pend_q`=0, `rsp_owner_q`=0.
- Reset outputs: `bmb_rsp_valid`=0, `bmb_cmd_ready`=0 and `mem_req`=0 while all valids are low.
- Reset asserted mid-burst or with a read in flight: the lock and the pending response are dropped immediately (asynchronous). Nothing is replayed.

## Structure
- Package `bmb_mem_pkg` holds:
  - `addr_t`, `data_t`, `strb_t`;
  - a `bmb_cmd_t` struct (address, size, wr, data, mask, last);
  - a `req_idx_t` typedef of width `$clog2(NumReq)`.
- Sub-module `rr_arbiter`:
  - inputs: request vector, `rr_ptr`, lock, owner;
  - output: a one-hot and encoded `sel`;
  - purely combinational.
- `rr_ptr`, the lock and owner state, and the response registers stay in the top module.

## Test plan
- Single read on requester 0 at 0x80000000, `mem_gnt`=1: `mem_addr`=0x80000000 in cycle N, `bmb_rsp_valid`=2'b01 in N+1 with data = `mem_rdata`.
- Both requesters issue single-beat reads every cycle, `mem_gnt`=1: grants alternate 0,1,0,1 starting at requester 0, and each response is routed to the matching requester one cycle later.
- Requester 1 issues a 4-beat command (`last` set on beat 4) while requester 0 is valid throughout: requester 1 receives all 4 beats consecutively, requester 0 is granted on the following cycle, and `rr_ptr`=0 afterwards.
- `mem_gnt` held low for 3 cycles with requester 0 valid: `bmb_cmd_ready`=0 throughout and no response appears. Release `mem_gnt`: exactly one beat is accepted.
- Write with `mask`=0xF0 from requester 1: `mem_we`=1 and `mem_strb`=0xF0, and no `bmb_rsp_valid` follows.
- Assert `rst_ni` low in the middle of a 4-beat lock, with a read in flight: all `bmb_rsp_valid`=0 and the state returns to `IDLE` with `rr_ptr`=0. After reset, requester 0 wins the first simultaneous request.
